// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the UART receive controller slice.
//   - One-hot Rx FSM state codes as driven by RxCore on State_i.
//   - Controller state encoding (IDLE / COLLECT / CHECK).
//   - Parity mode constants and the parity check helper.
//   - Default watchdog limit (3 bit times at 16x oversampling).
// -----------------------------------------------------------------------------
package rx_pkg;

    // One-hot Rx FSM states
    localparam logic [4:0] INTERVAL  = 5'b00001;
    localparam logic [4:0] STARTBIT  = 5'b00010;
    localparam logic [4:0] DATABITS  = 5'b00100;
    localparam logic [4:0] PARITYBIT = 5'b01000;
    localparam logic [4:0] STOPBIT   = 5'b10000;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } ctrl_state_t;

    // Parity modes; the value is also the XOR a good frame must produce
    // over the 8 data bits plus the parity bit.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int WDOG_LIMIT_DEFAULT = 48;

    function automatic logic parity_error(input logic [7:0] data,
                                          input logic       par_bit,
                                          input logic       odd_mode);
        return (^{data, par_bit}) != (odd_mode ? PAR_ODD : PAR_EVEN);
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl_if
// Commit path from the frame controller to the Rx FIFO.
//   Byte_o       : committed byte (controller -> FIFO)
//   Byte_Valid_o : one-cycle write strobe (controller -> FIFO)
//   Fifo_Full_i  : FIFO full (FIFO -> controller)
//
// Handshake: Byte_Valid_o is the valid, !Fifo_Full_i is the ready. A byte is
// transferred in exactly the cycles where Byte_Valid_o=1; the controller never
// raises Byte_Valid_o while Fifo_Full_i=1 (that byte is dropped as overrun),
// so the FIFO may write unconditionally on Byte_Valid_o.
// -----------------------------------------------------------------------------
interface rx_frame_ctrl_if;
    logic [7:0] Byte_o;
    logic       Byte_Valid_o;
    logic       Fifo_Full_i;

    modport master (output Byte_o, output Byte_Valid_o, input Fifo_Full_i);
    modport slave  (input Byte_o, input Byte_Valid_o, output Fifo_Full_i);
endinterface

// File: rtl/rx_watchdog.sv
// -----------------------------------------------------------------------------
// rx_watchdog
// Counts AcqSig pulses between bit-end strobes while the Rx FSM is outside
// INTERVAL, and flags expiry when the LIMIT-th pulse arrives.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_interval  : Rx FSM is in INTERVAL (holds the count at zero)
//   bit_synch    : bit-end strobe (restarts the count)
//   acq          : 16x acquisition strobe (counted)
//   hit          : combinational, high in the cycle the LIMIT-th pulse is seen
// -----------------------------------------------------------------------------
module rx_watchdog
    import rx_pkg::*;
#(
    parameter int LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_interval,
    input  logic bit_synch,
    input  logic acq,
    output logic hit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // A bit strobe in the same cycle as a pulse restarts the count, so the
    // pulse never completes an expiry.
    assign hit = acq && !in_interval && !bit_synch && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || in_interval || bit_synch || hit) begin
            cnt_q <= '0;
        end else if (acq) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// Sequencing and commit controller beside the UART Rx FSM. Follows the one-hot
// Rx state and bit strobes, assembles the byte LSB first, checks parity and
// stop bit, and commits good bytes to the Rx FIFO. A bit-time watchdog (and
// any non-one-hot State_i) forces the Rx FSM back to INTERVAL.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   p_Enable_i        : Rx enable; low aborts a frame in progress
//   State_i           : one-hot Rx FSM state
//   Bit_Synch_i       : bit-end strobe, BitData_i valid with it
//   BitData_i         : sampled bit value
//   AcqSig_i          : 16x acquisition strobe (watchdog time base)
//   p_ParityEnable_i  : parity bit present
//   p_ParityOdd_i     : 1 = odd parity, 0 = even
//   fifo              : FIFO commit path (Byte_o, Byte_Valid_o, Fifo_Full_i)
//   Err_Clear_i       : clears sticky error flags (a same-cycle set wins)
//   ParityErr_o, FrameErr_o, Overrun_o : sticky error flags
//   WdogRst_o         : one-cycle pulse forcing the Rx FSM to INTERVAL
//   ByteCount_o       : committed byte count, wraps
//   Dbg_State_o       : controller state
// -----------------------------------------------------------------------------
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_Enable_i,
    input  logic [4:0]           State_i,
    input  logic                 Bit_Synch_i,
    input  logic                 BitData_i,
    input  logic                 AcqSig_i,
    input  logic                 p_ParityEnable_i,
    input  logic                 p_ParityOdd_i,
    rx_frame_ctrl_if.master      fifo,
    input  logic                 Err_Clear_i,
    output logic                 ParityErr_o,
    output logic                 FrameErr_o,
    output logic                 Overrun_o,
    output logic                 WdogRst_o,
    output logic [CNT_W-1:0]     ByteCount_o,
    output ctrl_state_t          Dbg_State_o
);

    ctrl_state_t      state_q;
    logic [7:0]       shreg_q;
    logic [7:0]       byte_q;
    logic [3:0]       bit_cnt_q;
    logic             par_q;
    logic             stop_q;
    logic             parity_err_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             wdog_rst_q;
    logic [CNT_W-1:0] byte_cnt_q;

    logic wdog_hit;
    logic illegal_state;
    logic force_idle;
    logic frame_err_c;
    logic parity_err_c;
    logic check_active;
    logic commit_c;
    logic set_frame;
    logic set_parity;
    logic set_overrun;

    rx_watchdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .in_interval (State_i == INTERVAL),
        .bit_synch   (Bit_Synch_i),
        .acq         (AcqSig_i),
        .hit         (wdog_hit)
    );

    assign illegal_state = !$onehot(State_i);
    assign force_idle    = wdog_hit || illegal_state;

    // Frame evaluation happens combinationally in the CHECK cycle so the write
    // strobe appears in the cycle right after the stop-bit strobe; the flags
    // and counter register at the end of that cycle.
    assign frame_err_c  = !stop_q || (bit_cnt_q != 4'd8);
    assign parity_err_c = p_ParityEnable_i && parity_error(shreg_q, par_q, p_ParityOdd_i);
    assign check_active = !rst && (state_q == CHECK) && p_Enable_i && !force_idle;
    assign commit_c     = check_active && !frame_err_c && !fifo.Fifo_Full_i;
    assign set_overrun  = check_active && !frame_err_c && fifo.Fifo_Full_i;
    assign set_frame    = (check_active && frame_err_c) || (!rst && force_idle);
    assign set_parity   = check_active && parity_err_c;

    assign fifo.Byte_Valid_o = commit_c;
    assign fifo.Byte_o       = commit_c ? shreg_q : byte_q;

    assign ParityErr_o = parity_err_q;
    assign FrameErr_o  = frame_err_q;
    assign Overrun_o   = overrun_q;
    assign WdogRst_o   = wdog_rst_q;
    assign ByteCount_o = byte_cnt_q;
    assign Dbg_State_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            byte_q       <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            wdog_rst_q   <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            wdog_rst_q <= force_idle;

            if (commit_c) begin
                byte_q     <= shreg_q;
                byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end

            if (set_parity)       parity_err_q <= 1'b1;
            else if (Err_Clear_i) parity_err_q <= 1'b0;

            if (set_frame)        frame_err_q <= 1'b1;
            else if (Err_Clear_i) frame_err_q <= 1'b0;

            if (set_overrun)      overrun_q <= 1'b1;
            else if (Err_Clear_i) overrun_q <= 1'b0;

            if (force_idle) begin
                // Stalled or corrupted frame: drop whatever was collected.
                state_q   <= IDLE;
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (State_i == STARTBIT && p_Enable_i) begin
                            state_q   <= COLLECT;
                            shreg_q   <= '0;
                            bit_cnt_q <= '0;
                            par_q     <= 1'b0;
                            stop_q    <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        if (!p_Enable_i) begin
                            state_q <= IDLE;
                        end else if (Bit_Synch_i) begin
                            if (State_i == DATABITS) begin
                                shreg_q <= {BitData_i, shreg_q[7:1]};
                                if (bit_cnt_q != 4'd8) bit_cnt_q <= bit_cnt_q + 4'd1;
                            end else if (State_i == PARITYBIT) begin
                                par_q <= BitData_i;
                            end else if (State_i == STOPBIT) begin
                                stop_q  <= BitData_i;
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        // A start bit already showing here is the next frame.
                        if (p_Enable_i && State_i == STARTBIT) begin
                            state_q   <= COLLECT;
                            shreg_q   <= '0;
                            bit_cnt_q <= '0;
                            par_q     <= 1'b0;
                            stop_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Directed bench for rx_frame_ctrl (CNT_W=8 so counter wrap is reachable).
// -----------------------------------------------------------------------------
module tb_rx_frame_ctrl;
    import rx_pkg::*;

    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             en;
    logic [4:0]       rx_state;
    logic             synch;
    logic             bdata;
    logic             acq;
    logic             par_en;
    logic             par_odd;
    logic             err_clr;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             wdog_rst;
    logic [CNT_W-1:0] byte_cnt;
    ctrl_state_t      dbg_state;

    rx_frame_ctrl_if bus ();

    rx_frame_ctrl #(
        .WDOG_LIMIT (48),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .p_Enable_i       (en),
        .State_i          (rx_state),
        .Bit_Synch_i      (synch),
        .BitData_i        (bdata),
        .AcqSig_i         (acq),
        .p_ParityEnable_i (par_en),
        .p_ParityOdd_i    (par_odd),
        .fifo             (bus.master),
        .Err_Clear_i      (err_clr),
        .ParityErr_o      (parity_err),
        .FrameErr_o       (frame_err),
        .Overrun_o        (overrun),
        .WdogRst_o        (wdog_rst),
        .ByteCount_o      (byte_cnt),
        .Dbg_State_o      (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame. Returns 1 time unit into the CHECK cycle with inputs
    // settled, Rx state set to 'after'.
    task automatic run_frame(input logic [7:0] d, input logic with_par,
                             input logic pbit, input logic stop,
                             input logic [4:0] after, input logic skip_start);
        if (!skip_start) begin
            rx_state = STARTBIT; synch = 1'b0;
            cyc();
        end
        for (int i = 0; i < 8; i++) begin
            rx_state = DATABITS; synch = 1'b1; bdata = d[i];
            cyc();
        end
        if (with_par) begin
            rx_state = PARITYBIT; synch = 1'b1; bdata = pbit;
            cyc();
        end
        rx_state = STOPBIT; synch = 1'b1; bdata = stop;
        cyc();
        rx_state = after; synch = 1'b0; bdata = 1'b0;
        #1;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b0 || bus.Byte_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_byte: got valid=%b byte=%h, need 0/00", bus.Byte_Valid_o, bus.Byte_o);
        end
        n_checks++;
        if ({parity_err, frame_err, overrun, wdog_rst} !== 4'b0000 || byte_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_flags: got flags=%b cnt=%0d, need 0000/0", {parity_err, frame_err, overrun, wdog_rst}, byte_cnt);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d, need IDLE", dbg_state);
        end
        rst = 1'b0;
        cyc();
        exp_cnt = 8'd0;
    endtask

    task automatic test_basic();
        run_frame(8'hA5, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b1 || bus.Byte_o !== 8'hA5) begin
            n_fail++; $display("FAIL basic_commit: got valid=%b byte=%h, need 1/a5", bus.Byte_Valid_o, bus.Byte_o);
        end
        cyc();
        exp_cnt = 8'd1;
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b0 || bus.Byte_o !== 8'hA5 || byte_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL basic_after: got valid=%b byte=%h cnt=%0d, need 0/a5/%0d", bus.Byte_Valid_o, bus.Byte_o, byte_cnt, exp_cnt);
        end
        n_checks++;
        if ({parity_err, frame_err, overrun} !== 3'b000) begin
            n_fail++; $display("FAIL basic_flags: got %b, need 000", {parity_err, frame_err, overrun});
        end
    endtask

    task automatic test_parity();
        par_en = 1'b1; par_odd = 1'b1;
        // 0x03 has two ones; parity bit 0 gives XOR 0, bad for odd parity.
        run_frame(8'h03, 1'b1, 1'b0, 1'b1, INTERVAL, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b1 || bus.Byte_o !== 8'h03) begin
            n_fail++; $display("FAIL parity_commit: got valid=%b byte=%h, need 1/03", bus.Byte_Valid_o, bus.Byte_o);
        end
        cyc();
        exp_cnt = 8'd2;
        n_checks++;
        if (parity_err !== 1'b1 || byte_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL parity_flag: got perr=%b cnt=%0d, need 1/%0d", parity_err, byte_cnt, exp_cnt);
        end
        // Clear and a new parity error in the same cycle: set wins.
        run_frame(8'h03, 1'b1, 1'b0, 1'b1, INTERVAL, 1'b0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        exp_cnt = 8'd3;
        n_checks++;
        if (parity_err !== 1'b1 || byte_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL parity_set_wins: got perr=%b cnt=%0d, need 1/%0d", parity_err, byte_cnt, exp_cnt);
        end
        clear_errors();
        n_checks++;
        if (parity_err !== 1'b0) begin
            n_fail++; $display("FAIL parity_clear: got %b, need 0", parity_err);
        end
        // Good odd frame: parity bit 1 makes XOR 1.
        run_frame(8'h03, 1'b1, 1'b1, 1'b1, INTERVAL, 1'b0);
        cyc();
        // Good even frame: parity bit 0 makes XOR 0.
        par_odd = 1'b0;
        run_frame(8'h03, 1'b1, 1'b0, 1'b1, INTERVAL, 1'b0);
        cyc();
        exp_cnt = 8'd5;
        n_checks++;
        if (parity_err !== 1'b0 || byte_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL parity_good: got perr=%b cnt=%0d, need 0/%0d", parity_err, byte_cnt, exp_cnt);
        end
        par_en = 1'b0;
    endtask

    task automatic test_frame_err();
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0, INTERVAL, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b0) begin
            n_fail++; $display("FAIL frame_no_commit: got valid=%b, need 0", bus.Byte_Valid_o);
        end
        cyc();
        n_checks++;
        if (frame_err !== 1'b1 || byte_cnt !== exp_cnt || bus.Byte_o !== 8'h03) begin
            n_fail++; $display("FAIL frame_flag: got ferr=%b cnt=%0d byte=%h, need 1/%0d/03", frame_err, byte_cnt, bus.Byte_o, exp_cnt);
        end
        clear_errors();
    endtask

    task automatic test_overrun();
        bus.Fifo_Full_i = 1'b1;
        run_frame(8'h7E, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b0) begin
            n_fail++; $display("FAIL overrun_no_commit: got valid=%b, need 0", bus.Byte_Valid_o);
        end
        cyc();
        bus.Fifo_Full_i = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || frame_err !== 1'b0 || byte_cnt !== exp_cnt || bus.Byte_o !== 8'h03) begin
            n_fail++; $display("FAIL overrun_flag: got ovr=%b ferr=%b cnt=%0d byte=%h, need 1/0/%0d/03", overrun, frame_err, byte_cnt, bus.Byte_o, exp_cnt);
        end
        run_frame(8'h81, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b1 || bus.Byte_o !== 8'h81) begin
            n_fail++; $display("FAIL overrun_next: got valid=%b byte=%h, need 1/81", bus.Byte_Valid_o, bus.Byte_o);
        end
        cyc();
        exp_cnt = 8'd6;
        clear_errors();
    endtask

    task automatic test_watchdog();
        rx_state = STARTBIT; synch = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            rx_state = DATABITS; synch = 1'b1; bdata = 1'b1;
            cyc();
        end
        synch = 1'b0;
        for (int p = 1; p <= 48; p++) begin
            acq = 1'b1;
            cyc();
            acq = 1'b0;
            if (p == 47) begin
                n_checks++;
                if (wdog_rst !== 1'b0 || dbg_state !== COLLECT) begin
                    n_fail++; $display("FAIL wdog_early: got wdog=%b state=%0d after 47 pulses, need 0/COLLECT", wdog_rst, dbg_state);
                end
            end
            if (p < 48) cyc();
        end
        n_checks++;
        if (wdog_rst !== 1'b1 || frame_err !== 1'b1 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL wdog_fire: got wdog=%b ferr=%b state=%0d, need 1/1/IDLE", wdog_rst, frame_err, dbg_state);
        end
        cyc();
        n_checks++;
        if (wdog_rst !== 1'b0 || byte_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL wdog_pulse: got wdog=%b cnt=%0d, need 0/%0d", wdog_rst, byte_cnt, exp_cnt);
        end
        rx_state = INTERVAL;
        clear_errors();
        run_frame(8'h11, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b1 || bus.Byte_o !== 8'h11) begin
            n_fail++; $display("FAIL wdog_recover: got valid=%b byte=%h, need 1/11", bus.Byte_Valid_o, bus.Byte_o);
        end
        cyc();
        exp_cnt = 8'd7;
    endtask

    task automatic test_illegal();
        rx_state = 5'b00110;
        cyc();
        rx_state = INTERVAL;
        n_checks++;
        if (wdog_rst !== 1'b1 || frame_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_multi: got wdog=%b ferr=%b, need 1/1", wdog_rst, frame_err);
        end
        cyc();
        clear_errors();
        rx_state = 5'b00000;
        cyc();
        rx_state = INTERVAL;
        n_checks++;
        if (wdog_rst !== 1'b1 || frame_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_zero: got wdog=%b ferr=%b, need 1/1", wdog_rst, frame_err);
        end
        cyc();
        clear_errors();
    endtask

    task automatic test_abort();
        rx_state = STARTBIT; synch = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            rx_state = DATABITS; synch = 1'b1; bdata = 1'b1;
            cyc();
        end
        synch = 1'b0; en = 1'b0;
        cyc();
        n_checks++;
        if (dbg_state !== IDLE || bus.Byte_Valid_o !== 1'b0 || wdog_rst !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL abort: got state=%0d valid=%b wdog=%b ferr=%b, need IDLE/0/0/0", dbg_state, bus.Byte_Valid_o, wdog_rst, frame_err);
        end
        en = 1'b1; rx_state = INTERVAL;
        cyc();
        n_checks++;
        if (byte_cnt !== exp_cnt || bus.Byte_o !== 8'h11) begin
            n_fail++; $display("FAIL abort_no_commit: got cnt=%0d byte=%h, need %0d/11", byte_cnt, bus.Byte_o, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(8'h3C, 1'b0, 1'b0, 1'b1, STARTBIT, 1'b0);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b1 || bus.Byte_o !== 8'h3C) begin
            n_fail++; $display("FAIL b2b_first: got valid=%b byte=%h, need 1/3c", bus.Byte_Valid_o, bus.Byte_o);
        end
        cyc();
        exp_cnt = 8'd8;
        n_checks++;
        if (dbg_state !== COLLECT || byte_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL b2b_state: got state=%0d cnt=%0d, need COLLECT/%0d", dbg_state, byte_cnt, exp_cnt);
        end
        run_frame(8'hC3, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b1);
        n_checks++;
        if (bus.Byte_Valid_o !== 1'b1 || bus.Byte_o !== 8'hC3) begin
            n_fail++; $display("FAIL b2b_second: got valid=%b byte=%h, need 1/c3", bus.Byte_Valid_o, bus.Byte_o);
        end
        cyc();
        exp_cnt = 8'd9;
    endtask

    task automatic test_wrap();
        while (exp_cnt != 8'hFF) begin
            run_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
            cyc();
            exp_cnt = exp_cnt + 8'd1;
        end
        n_checks++;
        if (byte_cnt !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_full: got %0d, need 255", byte_cnt);
        end
        run_frame(8'h55, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
        cyc();
        exp_cnt = 8'd0;
        n_checks++;
        if (byte_cnt !== 8'h00 || bus.Byte_o !== 8'h55) begin
            n_fail++; $display("FAIL wrap_zero: got cnt=%0d byte=%h, need 0/55", byte_cnt, bus.Byte_o);
        end
    endtask

    task automatic test_rst_mid();
        run_frame(8'hE7, 1'b0, 1'b0, 1'b1, INTERVAL, 1'b0);
        cyc();
        rx_state = 5'b00000;
        cyc();
        rx_state = STARTBIT; synch = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            rx_state = DATABITS; synch = 1'b1; bdata = 1'b1;
            cyc();
        end
        rst = 1'b1;
        cyc();
        n_checks++;
        if (bus.Byte_o !== 8'h00 || bus.Byte_Valid_o !== 1'b0 || byte_cnt !== 8'd0 ||
            {parity_err, frame_err, overrun, wdog_rst} !== 4'b0000 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL rst_mid: got byte=%h valid=%b cnt=%0d flags=%b state=%0d, need all 0/IDLE",
                               bus.Byte_o, bus.Byte_Valid_o, byte_cnt, {parity_err, frame_err, overrun, wdog_rst}, dbg_state);
        end
        rst = 1'b0; synch = 1'b0; rx_state = INTERVAL;
        cyc();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1; en = 1'b1; rx_state = INTERVAL; synch = 1'b0; bdata = 1'b0;
        acq = 1'b0; par_en = 1'b0; par_odd = 1'b0; err_clr = 1'b0;
        bus.Fifo_Full_i = 1'b0;
        exp_cnt = '0;

        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_watchdog();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_wrap();
        test_rst_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Sequencing and commit controller that sits beside the UART Rx FSM in RxCore.
- Tracks the Rx FSM one-hot state and bit-end strobes, and assembles the data byte LSB first.
- Checks parity and stop bit, then commits each good byte to the Rx FIFO with a one-cycle write strobe.
- Runs a bit-time watchdog that forces the Rx FSM back to INTERVAL when a frame stalls.

Parameters:
- WDOG_LIMIT, 48: AcqSig_i pulses allowed between consecutive Bit_Synch_i strobes while the Rx FSM is not in INTERVAL (3 bit times at 16x oversampling).
- CNT_W, 16: width of the committed-byte counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- p_Enable_i  in  1  Rx enable; low aborts any frame in progress
- State_i  in  5  one-hot Rx FSM state: INTERVAL=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000
- Bit_Synch_i  in  1  bit-end strobe from ShiftRegister_Rx
- BitData_i  in  1  sampled bit value, valid with Bit_Synch_i
- AcqSig_i  in  1  16x acquisition strobe from the baud generator
- p_ParityEnable_i  in  1  parity bit present in frame
- p_ParityOdd_i  in  1  1 = odd parity, 0 = even parity
- Fifo_Full_i  in  1  Rx FIFO full
- Err_Clear_i  in  1  clears all sticky error flags
- Byte_o  out  8  committed byte, held until the next commit
- Byte_Valid_o  out  1  one-cycle FIFO write strobe
- ParityErr_o  out  1  sticky parity error
- FrameErr_o  out  1  sticky framing error
- Overrun_o  out  1  sticky overrun
- WdogRst_o  out  1  one-cycle pulse forcing the Rx FSM to INTERVAL
- ByteCount_o  out  CNT_W  number of committed bytes

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. While rst is high all outputs are 0, the controller is in IDLE, and the shift register, bit count and watchdog count are 0.
- Controller states: IDLE, COLLECT, CHECK.
- IDLE -> COLLECT: State_i==STARTBIT and p_Enable_i=1. On entry, bit count and shift register are cleared.
- COLLECT, data bits: on Bit_Synch_i with State_i==DATABITS, shift right and load BitData_i into bit 7; bit count +1, saturating at 8.
- COLLECT, parity: on Bit_Synch_i with State_i==PARITYBIT, capture the parity bit.
- COLLECT -> CHECK: Bit_Synch_i with State_i==STOPBIT; the stop bit value is captured.
- CHECK always takes exactly one cycle, then returns to IDLE. If State_i==STARTBIT in that same cycle, go to COLLECT instead, to support back-to-back frames.
- CHECK error evaluation:
  - Frame error: stop bit 0, or bit count not equal to 8.
  - Parity error (parity enabled only): even parity requires XOR of the 8 data bits and the parity bit to equal 0; odd parity requires it to equal 1.
- CHECK commit rules:
  - Frame error: byte discarded, FrameErr_o set.
  - Otherwise, Fifo_Full_i=1: byte discarded, Overrun_o set.
  - Otherwise: Byte_o updated, Byte_Valid_o=1 for one cycle, ByteCount_o +1 (wraps to 0 at all-ones).
  - A parity error sets ParityErr_o and the byte is still committed.
- Latency: Byte_Valid_o is asserted in the cycle after the stop-bit Bit_Synch_i is sampled.
- Sticky flags:
  - Set only by the CHECK conditions above; cleared by Err_Clear_i.
  - If Err_Clear_i and a new error set occur in the same cycle, set wins.
- Abort on p_Enable_i=0 in COLLECT or CHECK: go to IDLE next cycle; no commit, no flag change, no WdogRst_o.
- Watchdog:
  - Count AcqSig_i pulses while State_i != INTERVAL; the count clears on Bit_Synch_i and whenever State_i==INTERVAL.
  - When the count reaches WDOG_LIMIT: WdogRst_o=1 for one cycle, FrameErr_o set, controller to IDLE, partial byte discarded, count cleared.
- Illegal State_i (not one-hot, including all zeros): same action as watchdog expiry on the next cycle.
- Bit_Synch_i while in IDLE is ignored.

Decomposition:
- Shared package rx_pkg:
  - Rx FSM one-hot state constants: INTERVAL, STARTBIT, DATABITS, PARITYBIT, STOPBIT.
  - Controller state encoding: IDLE, COLLECT, CHECK.
  - Parity mode constants.
  - WDOG_LIMIT default.
- One sub-module: rx_watchdog (AcqSig_i counter, clear logic, expiry pulse). All other logic lives in rx_frame_ctrl.

Test Plan:
- Parity off, frame 0xA5 with stop=1, FIFO not full -> one cycle after the stop Bit_Synch_i: Byte_o=0xA5, Byte_Valid_o pulses once, ByteCount_o=1, no flags set.
- Odd parity, 0x03 sent with parity bit 0 -> byte 0x03 committed, ParityErr_o=1. Then Err_Clear_i held in the same cycle as a second bad-parity CHECK -> ParityErr_o stays 1.
- 0x5A with stop=0 -> no Byte_Valid_o, FrameErr_o=1, ByteCount_o unchanged.
- Fifo_Full_i=1 during CHECK of 0x7E -> no Byte_Valid_o, Overrun_o=1. Next frame 0x81 with Fifo_Full_i=0 -> committed.
- State_i held at DATABITS for 48 AcqSig_i pulses with no Bit_Synch_i -> WdogRst_o pulses on the 48th, FrameErr_o=1. A following good frame 0x11 -> committed normally.
- p_Enable_i dropped after 4 data bits -> controller in IDLE next cycle, no commit. rst asserted mid-frame -> all outputs 0 on the following edge. ByteCount_o preset by 0xFFFF commits, then one more commit -> wraps to 0x0000.
